// File: rtl/perf_pkg.sv
// Shared types and default sizes for the account-ranking scheduler.
// The entry layout is fixed at DSIZE_DEF; instantiate the top with DSIZE equal to it.
package perf_pkg;

    localparam int unsigned DSIZE_DEF = 8;
    localparam int unsigned WIN_DEF   = 5;
    localparam int unsigned FRAME_DEF = 4000;

    typedef struct packed {
        logic [DSIZE_DEF-1:0]   account;
        logic [2*DSIZE_DEF-1:0] prod;
    } entry_t;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH
    } state_t;

endpackage

// File: rtl/win_argmin.sv
// Combinational argmin over the sliding window; index 0 is the newest entry.
// Ties resolve toward the newest entry.
module win_argmin
    import perf_pkg::*;
#(
    parameter int unsigned WIN = WIN_DEF
) (
    input  entry_t               win_i [WIN],
    output logic [DSIZE_DEF-1:0] account_o
);

    entry_t best;

    // NOTE: best is assigned before the loop reads it, so no latch is inferred.
    always_comb begin
        best = win_i[WIN-1];
        for (int i = WIN - 2; i >= 0; i--) begin
            if (win_i[i].prod <= best.prod) begin
                best = win_i[i];
            end
        end
        account_o = best.account;
    end

endmodule

// File: rtl/perf_window_sched.sv
// clk2-side scheduler: pops {account, A, T}, forms A*T, and emits the account with the
// minimum product over the last WIN entries of the current frame.
module perf_window_sched
    import perf_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF,
    parameter int unsigned WIN   = WIN_DEF,
    parameter int unsigned FRAME = FRAME_DEF
) (
    input  logic               clk2,
    input  logic               rst_n,
    input  logic               fifo_empty,
    input  logic [3*DSIZE-1:0] fifo_rdata,
    output logic               fifo_rinc,
    output logic               out_valid,
    output logic [DSIZE-1:0]   out_account
);

    localparam int unsigned PW  = 2 * DSIZE;
    localparam int unsigned WCW = $clog2(WIN + 1);
    localparam int unsigned FCW = $clog2(FRAME + 1);

    state_t           state_q, state_d;
    logic [WCW-1:0]   win_cnt_q, win_cnt_d;
    logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
    entry_t           s1_q;
    logic             s1_v_q;
    entry_t           win_q [WIN];
    logic             w_v_q;
    logic             out_valid_q;
    logic [DSIZE-1:0] out_account_q;
    logic [DSIZE-1:0] acc_in, a_in, t_in;
    logic [DSIZE-1:0] min_account;

    assign {acc_in, a_in, t_in} = fifo_rdata;
    assign fifo_rinc   = !fifo_empty && (state_q != FLUSH);
    assign out_valid   = out_valid_q;
    assign out_account = out_account_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s1_v_q <= 1'b0;
        end else begin
            s1_v_q <= fifo_rinc;
            if (fifo_rinc) begin
                s1_q.account <= acc_in;
                s1_q.prod    <= PW'(a_in) * PW'(t_in);
            end
        end
    end

    // NOTE: the window storage is cleared on reset so no stale account survives a reset.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN; i++) begin
                win_q[i] <= '0;
            end
            w_v_q <= 1'b0;
        end else begin
            w_v_q <= s1_v_q;
            if (s1_v_q) begin
                win_q[0] <= s1_q;
                for (int i = 1; i < WIN; i++) begin
                    win_q[i] <= win_q[i-1];
                end
            end
        end
    end

    win_argmin #(
        .WIN (WIN)
    ) u_argmin (
        .win_i     (win_q),
        .account_o (min_account)
    );

    // A result is due one cycle after the window takes an entry, once the window is full.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_account_q <= '0;
        end else begin
            out_valid_q   <= w_v_q && (win_cnt_q == WCW'(WIN));
            out_account_q <= (w_v_q && (win_cnt_q == WCW'(WIN))) ? min_account : '0;
        end
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            win_cnt_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        frame_cnt_d = frame_cnt_q;

        if (s1_v_q && (win_cnt_q != WCW'(WIN))) begin
            win_cnt_d = win_cnt_q + 1'b1;
        end
        if (fifo_rinc) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end

        unique case (state_q)
            FILL: begin
                if (s1_v_q && (win_cnt_q == WCW'(WIN - 1))) begin
                    state_d = RUN;
                end
            end
            RUN: ;
            FLUSH: begin
                // Both pipeline stages empty: the frame's last result has left.
                if (!s1_v_q && !w_v_q) begin
                    state_d     = FILL;
                    win_cnt_d   = '0;
                    frame_cnt_d = '0;
                end
            end
            default: state_d = FILL;
        endcase

        if (fifo_rinc && (frame_cnt_q == FCW'(FRAME - 1))) begin
            state_d = FLUSH;
        end
    end

endmodule

// File: tb/tb_perf_window_sched.sv
// Scoreboard bench for perf_window_sched: a FIFO model feeds the DUT, a frame-level
// reference model predicts each result and its cycle, and a monitor compares them.
module tb_perf_window_sched;

    localparam int DSIZE = 8;
    localparam int WIN   = 5;
    localparam int FRAME = 8;

    logic             clk2 = 1'b0;
    logic             rst_n = 1'b0;
    logic             fifo_empty = 1'b1;
    logic [3*DSIZE-1:0] fifo_rdata = '0;
    logic             fifo_rinc;
    logic             out_valid;
    logic [DSIZE-1:0] out_account;

    always #5 clk2 = ~clk2;

    perf_window_sched #(
        .DSIZE (DSIZE),
        .WIN   (WIN),
        .FRAME (FRAME)
    ) dut (
        .clk2        (clk2),
        .rst_n       (rst_n),
        .fifo_empty  (fifo_empty),
        .fifo_rdata  (fifo_rdata),
        .fifo_rinc   (fifo_rinc),
        .out_valid   (out_valid),
        .out_account (out_account)
    );

    typedef struct {int acct; int a; int t;} ent_t;
    typedef struct {int acct; int due;} exp_t;

    ent_t src[$];
    ent_t frame_q[$];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int results_seen = 0;
    int last_acct = 0;
    int gap_pct = 0;
    int flush_hold = 0;
    int base;

    always @(posedge clk2) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: the result for a popped entry is the minimum-product account among the
    // last WIN entries of its frame (newest on ties), due two edges after its pop.
    function automatic void model_pop(ent_t e, int k);
        int minv;
        int pick;
        int lo;
        frame_q.push_back(e);
        if (frame_q.size() >= WIN) begin
            lo = frame_q.size() - WIN;
            minv = 1 << 30;
            pick = -1;
            for (int j = lo; j < frame_q.size(); j++)
                if (frame_q[j].a * frame_q[j].t < minv) minv = frame_q[j].a * frame_q[j].t;
            for (int j = lo; j < frame_q.size(); j++)
                if (frame_q[j].a * frame_q[j].t == minv) pick = frame_q[j].acct;
            sb.push_back('{pick, k + 2});
        end
        if (frame_q.size() == FRAME) begin
            frame_q.delete();
            flush_hold = 2;
        end
    endfunction

    task automatic push(int acct, int a, int t);
        src.push_back('{acct, a, t});
    endtask

    task automatic step(bit force_gap);
        bit   gap;
        bit   will_pop;
        ent_t e;
        @(negedge clk2);
        gap = force_gap || ($urandom_range(99) < gap_pct);
        fifo_empty = gap || (src.size() == 0);
        if (fifo_empty) fifo_rdata = 24'($urandom);
        else fifo_rdata = {8'(src[0].acct), 8'(src[0].a), 8'(src[0].t)};
        #1;
        will_pop = fifo_rinc;
        if (fifo_empty) check("rinc_while_empty", fifo_rinc, 0);
        if (flush_hold > 0) begin
            check("rinc_in_flush", fifo_rinc, 0);
            flush_hold--;
        end
        @(posedge clk2);
        #1;
        if (will_pop) begin
            e = src.pop_front();
            model_pop(e, cyc);
        end
    endtask

    task automatic drain(string name);
        int budget = 0;
        while ((src.size() != 0 || sb.size() != 0) && budget < 300) begin
            step(0);
            budget++;
        end
        check({name, "_drained"}, src.size() + sb.size(), 0);
        repeat (4) step(0);
    endtask

    task automatic do_reset(int ncyc);
        #1;
        rst_n = 1'b0;
        fifo_empty = 1'b1;
        src.delete();
        sb.delete();
        frame_q.delete();
        flush_hold = 0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_account", out_account, 0);
        check("rst_rinc", fifo_rinc, 0);
        repeat (ncyc) begin
            @(negedge clk2);
            #1;
            check("rst_hold_rinc", fifo_rinc, 0);
            check("rst_hold_account", out_account, 0);
        end
        @(posedge clk2);
        #2;
        rst_n = 1'b1;
    endtask

    always @(negedge clk2) begin
        exp_t x;
        if (!rst_n) begin
            check("reset_valid", out_valid, 0);
        end else if (out_valid) begin
            results_seen++;
            last_acct = out_account;
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                x = sb.pop_front();
                check("result_account", out_account, x.acct);
                check("result_cycle", cyc, x.due);
            end
        end else begin
            check("idle_account", out_account, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;

        do_reset(3);

        base = results_seen;
        for (int i = 0; i < 5; i++) push(1 + i, 10 - i, 10 - i);
        drain("t2");
        check("t2_count", results_seen - base, 1);
        check("t2_acct", last_acct, 5);

        do_reset(2);
        base = results_seen;
        for (int i = 0; i < 7; i++) push(11 + i, 10, 10);
        drain("t3");
        check("t3_count", results_seen - base, 3);
        check("t3_acct", last_acct, 17);

        do_reset(2);
        base = results_seen;
        for (int i = 0; i < 6; i++) push(21 + i, $urandom_range(1, 15), $urandom_range(1, 15));
        drain("t4a");
        push(27, $urandom_range(1, 15), $urandom_range(1, 15));
        repeat (20) step(1);
        check("t4_gap_pending", src.size(), 1);
        drain("t4b");
        check("t4_count", results_seen - base, 3);

        do_reset(2);
        base = results_seen;
        for (int i = 0; i < 10; i++) push(31 + i, $urandom_range(0, 255), $urandom_range(0, 255));
        drain("t5");
        check("t5_count", results_seen - base, 4);

        do_reset(2);
        base = results_seen;
        push(41, 255, 255);
        push(42, 255, 254);
        push(43, 254, 255);
        push(44, 254, 254);
        push(45, 255, 255);
        drain("t6");
        check("t6_count", results_seen - base, 1);
        check("t6_acct", last_acct, 44);

        do_reset(2);
        base = results_seen;
        for (int i = 0; i < 8; i++) push(51 + i, $urandom_range(1, 20), $urandom_range(1, 20));
        budget = 0;
        while (results_seen - base < 3 && budget < 100) begin
            step(0);
            budget++;
        end
        check("t7_first_results", results_seen - base, 3);
        do_reset(1);
        base = results_seen;
        for (int i = 0; i < 4; i++) push(61 + i, 3, 3);
        drain("t7a");
        check("t7_none_before_fifth", results_seen - base, 0);
        push(65, 3, 3);
        drain("t7b");
        check("t7_count", results_seen - base, 1);
        check("t7_acct", last_acct, 65);

        do_reset(2);
        gap_pct = 30;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(1) == 0) push($urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 3));
            else push($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        end
        drain("rand_gaps");
        gap_pct = 0;
        for (int i = 0; i < 40; i++) push($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        drain("rand_b2b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
